// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 image decryptor.
package rc4_pkg;

    localparam int SBOX_SIZE = 256;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INIT      = 3'd1,
        KSA       = 3'd2,
        PRGA_SWAP = 3'd3,
        PRGA_XOR  = 3'd4,
        DRAIN     = 3'd5,
        DONE      = 3'd6,
        ERROR     = 3'd7
    } rc4_state_t;

    // Keystream lookup index: S[i] + S[j] wrapping at 256.
    function automatic logic [7:0] ks_index(input logic [7:0] s_i, input logic [7:0] s_j);
        return s_i + s_j;
    endfunction

endpackage

// File: rtl/rc4_sbox.sv
// 256-entry RC4 permutation state with two index read ports, one keystream read
// port, an identity-init write and a single-cycle swap write.
module rc4_sbox
    import rc4_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       init_en,
    input  logic       swap_en,
    input  logic [7:0] idx_a,
    input  logic [7:0] idx_b,
    input  logic [7:0] idx_k,
    output logic [7:0] rd_a,
    output logic [7:0] rd_b,
    output logic [7:0] rd_k
);

    logic [7:0] s_q [SBOX_SIZE];

    assign rd_a = s_q[idx_a];
    assign rd_b = s_q[idx_b];
    assign rd_k = s_q[idx_k];

    // S-box storage; a swap with idx_a == idx_b rewrites the same value.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int n = 0; n < SBOX_SIZE; n++) begin
                s_q[n] <= 8'h00;
            end
        end else if (init_en) begin
            s_q[idx_a] <= idx_a;
        end else if (swap_en) begin
            s_q[idx_a] <= s_q[idx_b];
            s_q[idx_b] <= s_q[idx_a];
        end
    end

endmodule

// File: rtl/rc4_decryptor.sv
// RC4 stream decryptor: KSA from the key, then one keystream byte XORed onto each
// accepted ciphertext byte, with a registered valid/ready plaintext output.
module rc4_decryptor
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 16,
    parameter int IMG_BYTES = 4096,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   rc4_start,
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic [4:0]             key_len,
    input  logic                   cipher_valid,
    input  logic [7:0]             cipher_data,
    output logic                   cipher_ready,
    output logic                   plain_valid,
    output logic [7:0]             plain_data,
    input  logic                   plain_ready,
    output logic                   rc4_done,
    output logic                   rc4_error
);

    rc4_state_t       state_q, state_d;
    logic [7:0]       i_q, i_d;
    logic [7:0]       j_q, j_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [4:0]       kidx_q, kidx_d;
    logic [4:0]       klen_q, klen_d;
    logic             pv_q, pv_d;
    logic [7:0]       pd_q, pd_d;

    logic [7:0]             idx_a_s, idx_b_s, idx_k_s;
    logic [7:0]             rd_a_s, rd_b_s, rd_k_s;
    logic [7:0]             i_inc_s, j_ksa_s, j_prga_s, key_byte_s;
    logic [8*KEY_BYTES-1:0] key_sh_s;
    logic [4:0]             kidx_inc_s;
    logic                   klen_ok_s, ready_s, accept_s, active_s;

    // Key byte selection by shifting avoids a key_len divider.
    assign key_sh_s   = key >> {kidx_q, 3'b000};
    assign key_byte_s = key_sh_s[7:0];
    assign kidx_inc_s = kidx_q + 5'd1;
    assign klen_ok_s  = (key_len != 5'd0) && (32'(key_len) <= KEY_BYTES);

    assign i_inc_s  = i_q + 8'd1;
    assign j_ksa_s  = j_q + rd_a_s + key_byte_s;
    assign j_prga_s = j_q + rd_a_s;
    assign idx_a_s  = (state_q == PRGA_SWAP) ? i_inc_s : i_q;
    assign idx_b_s  = (state_q == KSA)       ? j_ksa_s :
                      (state_q == PRGA_SWAP) ? j_prga_s : j_q;
    assign idx_k_s  = ks_index(rd_a_s, rd_b_s);

    assign ready_s  = (state_q == PRGA_XOR) && rc4_start && (!pv_q || plain_ready);
    assign accept_s = ready_s && cipher_valid;
    assign active_s = (state_q == INIT) || (state_q == KSA) || (state_q == PRGA_SWAP) ||
                      (state_q == PRGA_XOR) || (state_q == DRAIN);

    rc4_sbox u_sbox (
        .clk     (clk),
        .n_rst   (n_rst),
        .init_en (state_q == INIT),
        .swap_en ((state_q == KSA) || (state_q == PRGA_SWAP)),
        .idx_a   (idx_a_s),
        .idx_b   (idx_b_s),
        .idx_k   (idx_k_s),
        .rd_a    (rd_a_s),
        .rd_b    (rd_b_s),
        .rd_k    (rd_k_s)
    );

    // Next-state, index/counter updates and plaintext output register.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        count_d = count_q;
        kidx_d  = kidx_q;
        klen_d  = klen_q;
        pv_d    = pv_q && !plain_ready;
        pd_d    = pd_q;

        if (accept_s) begin
            pv_d = 1'b1;
            pd_d = cipher_data ^ rd_k_s;
        end else begin
            pd_d = pd_q;
        end

        case (state_q)
            IDLE: begin
                if (rc4_start && klen_ok_s) begin
                    state_d = INIT;
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                    count_d = '0;
                    kidx_d  = 5'd0;
                    klen_d  = key_len;
                end else if (rc4_start) begin
                    state_d = ERROR;
                end else begin
                    state_d = IDLE;
                end
            end
            INIT: begin
                i_d = i_inc_s;
                if (i_q == 8'hFF) begin
                    state_d = KSA;
                end else begin
                    state_d = INIT;
                end
            end
            KSA: begin
                i_d    = i_inc_s;
                kidx_d = (kidx_inc_s == klen_q) ? 5'd0 : kidx_inc_s;
                if (i_q == 8'hFF) begin
                    state_d = PRGA_SWAP;
                    j_d     = 8'd0;
                end else begin
                    j_d     = j_ksa_s;
                end
            end
            PRGA_SWAP: begin
                i_d     = i_inc_s;
                j_d     = j_prga_s;
                state_d = PRGA_XOR;
            end
            PRGA_XOR: begin
                if (accept_s) begin
                    count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (count_d == CNT_W'(IMG_BYTES)) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = PRGA_SWAP;
                    end
                end else begin
                    state_d = PRGA_XOR;
                end
            end
            DRAIN: begin
                if (!pv_q || plain_ready) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE, ERROR: begin
                if (!rc4_start) begin
                    state_d = IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Dropping start mid-run abandons it silently.
        if (!rc4_start && active_s) begin
            state_d = IDLE;
            pv_d    = 1'b0;
        end else begin
            pv_d    = pv_d;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            count_q <= '0;
            kidx_q  <= 5'd0;
            klen_q  <= 5'd0;
            pv_q    <= 1'b0;
            pd_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            count_q <= count_d;
            kidx_q  <= kidx_d;
            klen_q  <= klen_d;
            pv_q    <= pv_d;
            pd_q    <= pd_d;
        end
    end

    assign cipher_ready = ready_s;
    assign plain_valid  = pv_q;
    assign plain_data   = pd_q;
    assign rc4_done     = (state_q == DONE);
    assign rc4_error    = (state_q == ERROR);

endmodule

// File: doc/rc4_decryptor.md
# rc4_decryptor

RC4 stream-cipher engine that turns the encrypted image byte stream into plaintext pixels for the edge-detection stage. The main control unit starts it with a level-held `rc4_start` and waits for `rc4_done` (or `rc4_error`) before moving on. Each run does three things: builds the 256-byte S-box from the key (KSA), generates one keystream byte per image byte (PRGA), and XORs it onto a valid/ready byte stream.

## Interface
- `KEY_BYTES`, default 16: maximum key length in bytes.
- `IMG_BYTES`, default 4096: bytes decrypted per run.
- `CNT_W`, default 16: width of the byte counter; must satisfy 2^CNT_W > IMG_BYTES.

Ports:
- `clk`  in  1: clock.
- `n_rst`  in  1: reset, asynchronous, active-low.
- `rc4_start`  in  1: level request from the main control unit; held high for the whole run.
- `key`  in  8*KEY_BYTES: key; key byte k is `key[8k+7:8k]`. Held stable during the run.
- `key_len`  in  5: number of valid key bytes, 1..KEY_BYTES. Sampled on start.
- `cipher_valid`  in  1: ciphertext byte available.
- `cipher_data`  in  8: ciphertext byte.
- `cipher_ready`  out  1: engine accepts the byte this cycle.
- `plain_valid`  out  1: plaintext byte held on `plain_data`.
- `plain_data`  out  8: plaintext byte.
- `plain_ready`  in  1: downstream accepts the byte.
- `rc4_done`  out  1: run completed.
- `rc4_error`  out  1: bad key length.

## Operation
States and transitions:
- **IDLE**
  - `rc4_start`=1 with `key_len` in 1..KEY_BYTES: go to INIT. i=0, j=0, count=0 at the same edge.
  - `rc4_start`=1 with `key_len`=0 or >KEY_BYTES: go to ERROR.
- **INIT**: S[i]=i, i++ (8-bit); 256 cycles. Leave when i wraps to 0.
- **KSA**: one cycle per i, 256 cycles.
  - j' = j + S[i] + key[i mod key_len], mod 256.
  - Swap S[i] and S[j'] in the same cycle; i++.
  - Leave to PRGA_SWAP when i wraps to 0, with j cleared.
- **PRGA_SWAP**: i' = i+1; j' = j + S[i']; swap S[i'] and S[j']. Always go to PRGA_XOR.
- **PRGA_XOR**
  - Keystream byte K = S[(S[i] + S[j]) mod 256], using post-swap values.
  - `cipher_ready` = !`plain_valid` || `plain_ready`.
  - On `cipher_valid` && `cipher_ready`: `plain_data` <= `cipher_data` ^ K, `plain_valid` <= 1, count++. Then go to PRGA_SWAP, or to DRAIN if count reaches IMG_BYTES.
- **DRAIN**: wait until `plain_valid`=0 or `plain_ready`=1, then go to DONE.
- **DONE**: `rc4_done`=1. Stay until `rc4_start`=0, then go to IDLE.
- **ERROR**: `rc4_error`=1. Stay until `rc4_start`=0, then go to IDLE.

Output register:
- `plain_valid` clears on `plain_ready` unless a new byte loads in the same cycle (accept and load together is legal).
- `plain_valid`/`plain_data` keep this behaviour in every state.

Abort:
- `rc4_start`=0 in INIT, KSA, PRGA_SWAP, PRGA_XOR or DRAIN: go to IDLE next edge. No done, no error; `plain_valid` cleared; `cipher_ready` low.

Arithmetic:
- All index arithmetic is 8-bit wrap-around.
- `key_len` compares are unsigned.
- Key index uses a 5-bit counter wrapping at `key_len`; no divider.

## Timing
- Reset values: state IDLE, i=j=0, count=0; all outputs 0, `plain_data`=0x00. S contents are don't-care after reset.
- `rc4_start` sampled high in IDLE at edge 0:
  - INIT occupies cycles 1–256.
  - KSA occupies 257–512.
  - PRGA_SWAP is cycle 513.
  - First `cipher_ready` is cycle 514.
- Steady-state throughput: one byte per 2 cycles.
- Plaintext appears the cycle after acceptance.
- `rc4_done` rises one cycle after the last byte leaves the output register. The main control unit drops `rc4_start` the following cycle, so `rc4_done` is a 1-cycle pulse.
- `rc4_error` asserts the cycle after start is sampled.
- `n_rst` low at any time forces reset values immediately.

## Structure
- `rc4_pkg`:
  - state enum `rc4_state_t` {IDLE, INIT, KSA, PRGA_SWAP, PRGA_XOR, DRAIN, DONE, ERROR};
  - `SBOX_SIZE`=256.
- Sub-module `rc4_sbox`: 256×8 flop array, `clk`/`n_rst`.
  - Two combinational read ports plus a third for the K lookup.
  - One swap port: `swap_en`, `idx_a`, `idx_b`, which writes both entries in one cycle.
  - An `init_en` port writing S[idx_a]=idx_a.
- Top level: FSM, i/j/count/key-index registers, output register.

## Test plan
- **Known vector.** Key "Key" (`key[23:0]`=0x79654B), `key_len`=3, IMG_BYTES=9. Ciphertext BB F3 16 E8 D9 40 AF 0A D3 → plaintext 50 6C 61 69 6E 74 65 78 74 ("Plaintext"). `rc4_done` pulses once.
- **Startup latency.** Start at edge 0 → `cipher_ready` first high at cycle 514. `plain_valid` asserts the cycle after the first accept.
- **Backpressure.** Hold `plain_ready`=0 for 10 cycles mid-stream → `cipher_ready`=0 and `plain_data` stable. Release → no byte lost or duplicated, same plaintext as the known vector.
- **Key length errors.**
  - `key_len`=0 → `rc4_error`=1 from cycle 1 until `rc4_start` drops; `cipher_ready` never high.
  - Repeat with `key_len`=17 → same response.
- **Abort mid-KSA.** Drop `rc4_start` at cycle 300 → IDLE next edge, no done or error. Restart → known vector passes.
- **Reset mid-stream.** `n_rst` low after 4 bytes → all outputs 0 immediately. Rerun → full correct 9 bytes.
